// File: rtl/sc_io_pkg.sv
// Shared constants for the sc_io_ports memory-mapped I/O block.
// Latency: n/a (constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package sc_io_pkg;
   // Word offsets within the 256-byte I/O page
   localparam logic [7:0] OFF_OUT    = 8'h00;
   localparam logic [7:0] OFF_IN     = 8'h40;
   localparam logic [7:0] OFF_STATUS = 8'h80;
   localparam logic [7:0] OFF_MASK   = 8'h84;

   // Each channel region is 16 words deep
   localparam int MAX_CH = 16;

   // Prime counter terminal value: flags are suppressed until the sync pipeline has filled
   localparam logic [1:0] PRIME_CNT = 2'd3;
endpackage

// File: rtl/sc_io_sync.sv
// Single input channel: 2-flop synchroniser, previous-value register, change pulse.
// Latency: sync_val follows din after 2 edges; change is combinational from s2/prev.
// Backpressure: none; samples every cycle.
`timescale 1ns/1ps
module sc_io_sync
   import sc_io_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              primed,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] sync_val,
   output logic              change
);

   logic [DATA_W-1:0] s1;
   logic [DATA_W-1:0] s2;
   logic [DATA_W-1:0] prev;

   // Two-stage synchroniser plus one-cycle history for edge detection
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1   <= '0;
         s2   <= '0;
         prev <= '0;
      end else begin
         s1   <= din;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign sync_val = s2;
   // Only report changes once the pipeline holds real samples, not reset zeros
   assign change   = primed && (s2 != prev);

endmodule

// File: rtl/sc_io_ports.sv
// Memory-mapped I/O page: N_OUT output registers, N_IN synchronised inputs, change STATUS (clear-on-read).
// Latency: reads combinational; writes visible next cycle; inputs 2 cycles; flags 3 cycles after input change.
// Backpressure: none; single-cycle CPU bus. Optional IRQ/MASK feature enabled by macro SC_IO_IRQ_EN.
`timescale 1ns/1ps
module sc_io_ports
   import sc_io_pkg::*;
#(
   parameter int N_IN    = 3,
   parameter int N_OUT   = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter logic [ADDR_W-9:0] IO_PAGE = '0
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic [ADDR_W-1:0]       addr,
   input  logic [DATA_W-1:0]       wdata,
   input  logic                    io_wr,
   input  logic                    io_rd,
   output logic [DATA_W-1:0]       rdata,
   output logic                    io_sel,
   input  logic [N_IN*DATA_W-1:0]  in_port,
   output logic [N_OUT*DATA_W-1:0] out_port,
   output logic                    irq
);

   localparam int CH_W = $clog2(MAX_CH);

   logic [7:0]              off;
   logic [CH_W-1:0]         ch;
   logic                    is_out, is_in, is_status;
   logic [1:0]              prime_cnt;
   logic                    primed;
   logic [N_IN*DATA_W-1:0]  in_sync;
   logic [N_IN-1:0]         chg;
   logic [N_IN-1:0]         flag;
   logic [DATA_W+MAX_CH-1:0] status_ext;
   logic                    status_clr;
   logic                    addr_unused;

   // Byte lanes within a word are not decoded
   assign addr_unused = ^addr[1:0];
   assign off        = {addr[7:2], 2'b00};
   assign ch         = off[5:2];
   assign io_sel     = (addr[ADDR_W-1:8] == IO_PAGE);
   assign is_out     = (off[7:6] == OFF_OUT[7:6]);
   assign is_in      = (off[7:6] == OFF_IN[7:6]);
   assign is_status  = (off == OFF_STATUS);
   assign status_clr = io_rd && io_sel && is_status;
   assign primed     = (prime_cnt == PRIME_CNT);

   // Per-channel synchronisers
   for (genvar g = 0; g < N_IN; g++) begin : g_in
      sc_io_sync #(.DATA_W(DATA_W)) u_sync (
         .clock    (clock),
         .resetn   (resetn),
         .primed   (primed),
         .din      (in_port[g*DATA_W +: DATA_W]),
         .sync_val (in_sync[g*DATA_W +: DATA_W]),
         .change   (chg[g])
      );
   end

   // Prime counter: counts up after reset and saturates
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                 prime_cnt <= '0;
      else if (prime_cnt != PRIME_CNT) prime_cnt <= prime_cnt + 2'd1;
   end

   // Change flags: a clearing read loses to a change detected in the same cycle
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) flag <= '0;
      else         flag <= (status_clr ? '0 : flag) | chg;
   end

   // Output registers written by CPU stores to OUT[i]
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out_port <= '0;
      end else if (io_wr && io_sel && is_out) begin
         for (int i = 0; i < N_OUT; i++) begin
            if (ch == CH_W'(i)) out_port[i*DATA_W +: DATA_W] <= wdata;
         end
      end
   end

`ifdef SC_IO_IRQ_EN
   logic [N_IN-1:0]          mask;
   logic [DATA_W+MAX_CH-1:0] wdata_ext;
   logic [DATA_W+MAX_CH-1:0] mask_ext;
   logic                     is_mask;

   assign is_mask   = (off == OFF_MASK);
   assign wdata_ext = {{MAX_CH{1'b0}}, wdata};

   // MASK register and registered interrupt request
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         mask <= '0;
         irq  <= 1'b0;
      end else begin
         if (io_wr && io_sel && is_mask) mask <= wdata_ext[N_IN-1:0];
         irq <= |(flag & mask);
      end
   end

   // Zero-extended mask for readback
   always_comb begin
      mask_ext         = '0;
      mask_ext[N_IN-1:0] = mask;
   end
`else
   assign irq = 1'b0;
`endif

   // Combinational read mux; unmapped offsets and absent channels return 0
   always_comb begin
      rdata              = '0;
      status_ext         = '0;
      status_ext[N_IN-1:0] = flag;
      if (io_sel) begin
         if (is_out) begin
            for (int i = 0; i < N_OUT; i++) begin
               if (ch == CH_W'(i)) rdata = out_port[i*DATA_W +: DATA_W];
            end
         end
         if (is_in) begin
            for (int i = 0; i < N_IN; i++) begin
               if (ch == CH_W'(i)) rdata = in_sync[i*DATA_W +: DATA_W];
            end
         end
         if (is_status) rdata = status_ext[DATA_W-1:0];
`ifdef SC_IO_IRQ_EN
         if (is_mask) rdata = mask_ext[DATA_W-1:0];
`endif
      end
   end

endmodule

// File: tb/tb_sc_io_ports.sv
// Directed bench for sc_io_ports with default parameters (3 in, 3 out, 32-bit).
// Latency: inputs driven 1ns after rising edge, outputs sampled 1ns later.
// Backpressure: n/a. IRQ steps run only when SC_IO_IRQ_EN is defined.
`timescale 1ns/1ps
module tb_sc_io_ports;

   logic        clock;
   logic        resetn;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        io_wr;
   logic        io_rd;
   logic [31:0] rdata;
   logic        io_sel;
   logic [95:0] in_port;
   logic [95:0] out_port;
   logic        irq;

   int passed = 0;
   int total  = 0;

   sc_io_ports dut (
      .clock    (clock),
      .resetn   (resetn),
      .addr     (addr),
      .wdata    (wdata),
      .io_wr    (io_wr),
      .io_rd    (io_rd),
      .rdata    (rdata),
      .io_sel   (io_sel),
      .in_port  (in_port),
      .out_port (out_port),
      .irq      (irq)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Set address, let combinational logic settle, compare rdata
   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(tag, 96'(rdata), 96'(exp));
   endtask

   initial begin
      resetn  = 1'b0;
      addr    = 32'h0;
      wdata   = 32'h0;
      io_wr   = 1'b0;
      io_rd   = 1'b0;
      in_port = '0;
      in_port[31:0] = 32'h55;
      #2;
      chk("rst_out_port", out_port, 96'h0);
      chk("rst_irq", 96'(irq), 96'h0);
      rd_chk("rst_status", 32'h80, 32'h0);

      // Step 1: release reset between edges; ch0 held at 0x55
      #10;
      resetn = 1'b1;
      tick();
      rd_chk("in0_after1", 32'h40, 32'h0);
      tick();
      rd_chk("in0_after2", 32'h40, 32'h55);
      for (int k = 0; k < 4; k++) begin
         rd_chk("status_prime", 32'h80, 32'h0);
         tick();
      end

      // Step 2: store to OUT[1]
      addr = 32'h04; wdata = 32'hDEADBEEF; io_wr = 1'b1;
      tick();
      io_wr = 1'b0;
      chk("out1_write", 96'(out_port[63:32]), 96'hDEADBEEF);
      chk("out0_keep", 96'(out_port[31:0]), 96'h0);
      chk("out2_keep", 96'(out_port[95:64]), 96'h0);
      rd_chk("out1_read", 32'h04, 32'hDEADBEEF);

      // Simultaneous read and write: read returns pre-write value
      wdata = 32'h12345678; io_wr = 1'b1; io_rd = 1'b1;
      rd_chk("rdwr_old", 32'h07, 32'hDEADBEEF);
      tick();
      io_wr = 1'b0; io_rd = 1'b0;
      chk("rdwr_new", 96'(out_port[63:32]), 96'h12345678);

      // Step 3: ch2 change 0 -> 7
      in_port[95:64] = 32'h7;
      tick(); tick();
      rd_chk("status_t2", 32'h80, 32'h0);
      tick();
      rd_chk("status_t3", 32'h80, 32'h4);
      io_rd = 1'b1;
      rd_chk("status_clr_rd", 32'h80, 32'h4);
      tick();
      io_rd = 1'b0;
      rd_chk("status_cleared", 32'h80, 32'h0);
      rd_chk("in2_read", 32'h48, 32'h7);

      // Step 4: ch1 changes, ch0 one cycle later; clear coincides with ch0 change pulse
      in_port[63:32] = 32'h1;
      tick();
      in_port[31:0] = 32'hAA;
      tick(); tick();
      io_rd = 1'b1;
      rd_chk("set_wins_rd", 32'h80, 32'h2);
      tick();
      io_rd = 1'b0;
      rd_chk("set_wins", 32'h80, 32'h1);
      io_rd = 1'b1;
      tick();
      io_rd = 1'b0;
      rd_chk("set_wins_clr", 32'h80, 32'h0);

      // Step 5: unmapped channel and foreign page
      addr = 32'h0C; wdata = 32'hFFFFFFFF; io_wr = 1'b1;
      #1;
      chk("oob_rdata", 96'(rdata), 96'h0);
      chk("oob_sel", 96'(io_sel), 96'h1);
      tick();
      io_wr = 1'b0;
      chk("oob_no_write", out_port, {32'h0, 32'h12345678, 32'h0});
      addr = 32'h104; wdata = 32'hCAFEF00D; io_wr = 1'b1;
      #1;
      chk("page_rdata", 96'(rdata), 96'h0);
      chk("page_sel", 96'(io_sel), 96'h0);
      tick();
      io_wr = 1'b0;
      chk("page_no_write", out_port, {32'h0, 32'h12345678, 32'h0});
      rd_chk("in3_absent", 32'h4C, 32'h0);
      rd_chk("unmapped_c0", 32'hC0, 32'h0);

`ifdef SC_IO_IRQ_EN
      // Step 6: masked interrupt
      addr = 32'h84; wdata = 32'h2; io_wr = 1'b1;
      tick();
      io_wr = 1'b0;
      rd_chk("mask_read", 32'h84, 32'h2);
      in_port[63:32] = 32'h3;
      tick(); tick(); tick();
      chk("irq_flag_cycle", 96'(irq), 96'h0);
      rd_chk("irq_status", 32'h80, 32'h2);
      tick();
      chk("irq_set", 96'(irq), 96'h1);
      io_rd = 1'b1;
      tick();
      io_rd = 1'b0;
      tick();
      chk("irq_clr", 96'(irq), 96'h0);
      in_port[31:0] = 32'h0;
      for (int k = 0; k < 5; k++) tick();
      rd_chk("irq_ch0_status", 32'h80, 32'h1);
      chk("irq_ch0_masked", 96'(irq), 96'h0);
`else
      rd_chk("mask_absent", 32'h84, 32'h0);
      chk("irq_tied", 96'(irq), 96'h0);
`endif

      // Reset mid-operation, then re-prime with non-zero inputs held
      #2;
      resetn = 1'b0;
      #1;
      chk("rst2_out", out_port, 96'h0);
      rd_chk("rst2_status", 32'h80, 32'h0);
      chk("rst2_irq", 96'(irq), 96'h0);
      #3;
      resetn = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      rd_chk("rst2_prime", 32'h80, 32'h0);
      rd_chk("rst2_in2", 32'h48, 32'h7);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
